// File: rtl/contador_pkg.sv
// contador_pkg: shared constants for the button-sequenced LED counter.
//   State encoding, direction encoding, default parameter values and a
//   helper that maps a direction onto the matching run state.
package contador_pkg;

  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_RUN_UP   = 2'd1;
  localparam logic [1:0] ST_RUN_DOWN = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int N_DEF       = 18;
  localparam int DB_BITS_DEF = 16;

  function automatic logic [1:0] run_state_for(input logic dir);
    return (dir == DIR_UP) ? ST_RUN_UP : ST_RUN_DOWN;
  endfunction

endpackage

// File: rtl/contador_ctrl_if.sv
// contador_ctrl_if: board-side signals of the LED counter controller.
//   SW1  start/stop pushbutton, active-high, asynchronous
//   SW2  direction pushbutton, active-high, asynchronous
//   LED0..LED7  count[0]..count[7]
//   master: drives the buttons and watches the LEDs (board / testbench)
//   slave : the controller
interface contador_ctrl_if;

  logic SW1;
  logic SW2;
  logic LED0;
  logic LED1;
  logic LED2;
  logic LED3;
  logic LED4;
  logic LED5;
  logic LED6;
  logic LED7;

  modport master (
    output SW1, SW2,
    input  LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7
  );

  modport slave (
    input  SW1, SW2,
    output LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7
  );

endinterface

// File: rtl/contador_ctrl_debouncer.sv
// debouncer: 2-FF synchroniser, stability counter and press-edge detector
// for one pushbutton.
//   CLK      system clock
//   RSTN     asynchronous active-low reset
//   i_btn    raw asynchronous button level (active-high)
//   o_press  one-cycle pulse on an accepted press; releases give no pulse
// A new level is accepted once the synchronised input has differed from the
// debounced value for 2^DB_BITS consecutive cycles.
module debouncer
  import contador_pkg::*;
#(
  parameter int DB_BITS = DB_BITS_DEF
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic i_btn,
  output logic o_press
);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db;
  logic               r_db_d;
  logic [DB_BITS-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (&r_cnt) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/contador_ctrl.sv
// contador_ctrl: button-sequenced 8-bit prescaled LED counter.
//   CLK   system clock (12 MHz on icezum)
//   RSTN  asynchronous active-low reset
//   bus   contador_ctrl_if.slave: SW1 start/stop, SW2 direction, LED0..LED7
// Parameters: N (prescaler width, one step per 2^N cycles while running),
//             DB_BITS (debounce counter width).
// Build option: define SATURATE_EN to stop at 255 (up) / 0 (down) instead
// of wrapping.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_STOPPED   | count and prescaler frozen, waiting for SW1
// ST_RUN_UP    | prescaler running, count +1 on every tick
// ST_RUN_DOWN  | prescaler running, count -1 on every tick
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DB_BITS = DB_BITS_DEF
) (
  input  logic            CLK,
  input  logic            RSTN,
  contador_ctrl_if.slave  bus
);

  logic         w_press1;
  logic         w_press2;
  logic         w_run;
  logic         w_tick;
  logic         w_dir_nxt;
  logic [1:0]   w_state_nxt;
  logic [N-1:0] w_presc_nxt;
  logic [7:0]   w_count_nxt;

  logic [1:0]   r_state;
  logic         r_dir;
  logic [N-1:0] r_presc;
  logic [7:0]   r_count;

  debouncer #(.DB_BITS(DB_BITS)) u_db_sw1 (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_btn   (bus.SW1),
    .o_press (w_press1)
  );

  debouncer #(.DB_BITS(DB_BITS)) u_db_sw2 (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_btn   (bus.SW2),
    .o_press (w_press2)
  );

  assign w_run     = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DOWN);
  assign w_tick    = w_run && (&r_presc);
  assign w_dir_nxt = w_press2 ? ~r_dir : r_dir;

`ifdef SATURATE_EN
  logic w_at_limit;
  assign w_at_limit = ((r_state == ST_RUN_UP)   && (r_count == 8'hFF)) ||
                      ((r_state == ST_RUN_DOWN) && (r_count == 8'h00));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_count_nxt = r_count;
    case (r_state)
      ST_STOPPED: begin
        // A simultaneous SW2 press already picks the toggled direction.
        if (w_press1) begin
          w_state_nxt = run_state_for(w_dir_nxt);
          w_presc_nxt = '0;
        end
      end
      ST_RUN_UP, ST_RUN_DOWN: begin
        // Stop beats a coincident tick: prescaler and count both hold.
        if (w_press1) begin
          w_state_nxt = ST_STOPPED;
        end else begin
          w_presc_nxt = r_presc + 1'b1;
          if (w_press2) begin
            w_state_nxt = (r_state == ST_RUN_UP) ? ST_RUN_DOWN : ST_RUN_UP;
          end
          // The step uses the direction in force before any SW2 toggle.
          if (w_tick) begin
            w_count_nxt = (r_state == ST_RUN_UP) ? r_count + 8'd1
                                                 : r_count - 8'd1;
`ifdef SATURATE_EN
            if (w_at_limit) begin
              w_count_nxt = r_count;
              w_state_nxt = ST_STOPPED;
            end
`endif
          end
        end
      end
      default: begin
        w_state_nxt = ST_STOPPED;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_STOPPED;
      r_dir   <= DIR_UP;
      r_presc <= '0;
      r_count <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_presc <= w_presc_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.LED0 = r_count[0];
  assign bus.LED1 = r_count[1];
  assign bus.LED2 = r_count[2];
  assign bus.LED3 = r_count[3];
  assign bus.LED4 = r_count[4];
  assign bus.LED5 = r_count[5];
  assign bus.LED6 = r_count[6];
  assign bus.LED7 = r_count[7];

endmodule

// File: tb/tb_contador_ctrl.sv
// tb_contador_ctrl: bench for contador_ctrl with N=3, DB_BITS=2.
// Honours SATURATE_EN the same way as the design build.
module tb_contador_ctrl;
  import contador_pkg::*;

  localparam int TN   = 3;
  localparam int TDB  = 2;
  localparam int PER  = 1 << TN;

  logic clk;
  logic rstn;
  logic [7:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  contador_ctrl_if bus ();

  contador_ctrl #(.N(TN), .DB_BITS(TDB)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  assign led = {bus.LED7, bus.LED6, bus.LED5, bus.LED4,
                bus.LED3, bus.LED2, bus.LED1, bus.LED0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buttons accepted after 2^DB_BITS consecutive differing
  // synchronised samples; counter steps once per 2^N running cycles.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_acc [2];
  bit m_accd [2];
  int m_diff [2];
  bit m_run;
  bit m_up;
  bit m_dir;
  int m_elapsed;
  int m_count;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_accd[b] = 0; m_diff[b] = 0;
    end
    m_run = 0; m_up = 1; m_dir = 0; m_elapsed = 0; m_count = 0;
  endtask

  task automatic model_update();
    bit p [2];
    bit sw [2];
    bit new_dir;
    sw[0] = bus.SW1;
    sw[1] = bus.SW2;
    for (int b = 0; b < 2; b++) begin
      p[b] = m_acc[b] && !m_accd[b];
      m_accd[b] = m_acc[b];
      if (m_s2[b] != m_acc[b]) begin
        m_diff[b]++;
        if (m_diff[b] == (1 << TDB)) begin
          m_acc[b] = m_s2[b];
          m_diff[b] = 0;
        end
      end else begin
        m_diff[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = sw[b];
    end
    new_dir = p[1] ? !m_dir : m_dir;
    if (!m_run) begin
      if (p[0]) begin
        m_run = 1;
        m_up = !new_dir;
        m_elapsed = 0;
      end
    end else if (p[0]) begin
      m_run = 0;
    end else begin
      if (m_elapsed % PER == PER - 1) begin
`ifdef SATURATE_EN
        if ((m_up && m_count == 255) || (!m_up && m_count == 0)) m_run = 0;
        else
`endif
        m_count = m_up ? (m_count + 1) % 256 : (m_count + 255) % 256;
      end
      m_elapsed++;
      if (p[1] && m_run) m_up = !m_up;
    end
    m_dir = new_dir;
  endtask

  function automatic logic [1:0] m_state();
    if (!m_run) return ST_STOPPED;
    return m_up ? ST_RUN_UP : ST_RUN_DOWN;
  endfunction

  // One clock: model follows the active edge, control returns at the negedge.
  task automatic cyc();
    @(posedge clk);
    if (rstn) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.SW1 = 1'b0;
    bus.SW2 = 1'b0;
    rstn = 1'b0;
    model_reset();
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic wait_led(input logic [7:0] v, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      cyc();
      if (led == v) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", led); end
    n_tests++;
    if (dut.r_state !== ST_STOPPED) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dut.r_state, ST_STOPPED); end
    n_tests++;
    if (dut.r_dir !== DIR_UP) begin n_fail++; $display("FAIL reset_dir got %0d want %0d", dut.r_dir, DIR_UP); end
    for (int i = 0; i < 100; i++) begin
      cyc();
      n_tests++;
      if (led !== 8'h00 || dut.r_state !== ST_STOPPED) begin
        n_fail++;
        $display("FAIL idle cycle %0d led %h state %0d want 00 / %0d", i, led, dut.r_state, ST_STOPPED);
      end
    end
  endtask

  task automatic test_press();
    logic [7:0] exp;
    do_reset();
    bus.SW1 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      cyc();
      exp = (k < 15) ? 8'h00 : (k < 23) ? 8'h01 : (k < 31) ? 8'h02 : 8'h03;
      n_tests++;
      if (led !== exp) begin n_fail++; $display("FAIL press_step edge %0d led %h want %h", k, led, exp); end
      n_tests++;
      if (dut.r_state !== ((k < 7) ? ST_STOPPED : ST_RUN_UP)) begin
        n_fail++;
        $display("FAIL press_state edge %0d got %0d want %0d", k, dut.r_state, (k < 7) ? ST_STOPPED : ST_RUN_UP);
      end
    end
    bus.SW1 = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    bus.SW1 = 1'b1;
    cyc(); cyc(); cyc();
    bus.SW1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_tests++;
      if (led !== 8'h00 || dut.r_state !== ST_STOPPED) begin
        n_fail++;
        $display("FAIL glitch cycle %0d led %h state %0d want 00 / 0", i, led, dut.r_state);
      end
    end
    bus.SW1 = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      if (i == 21) bus.SW1 = 1'b0;
      cyc();
      n_tests++;
      if (led !== m_count[7:0] || dut.r_state !== m_state()) begin
        n_fail++;
        $display("FAIL hold cycle %0d led %h state %0d want %h / %0d", i, led, dut.r_state, m_count[7:0], m_state());
      end
    end
    n_tests++;
    if (led !== 8'h05 || dut.r_state !== ST_RUN_UP) begin
      n_fail++;
      $display("FAIL hold_single_press led %h state %0d want 05 / %0d", led, dut.r_state, ST_RUN_UP);
    end
  endtask

  task automatic test_direction();
    bit ok;
    logic [7:0] q[$];
    logic [7:0] prev;
    do_reset();
    bus.SW1 = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    bus.SW1 = 1'b0;
    wait_led(8'h02, 40, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL dir_reach2 led %h want 02", led); end
    bus.SW2 = 1'b1;
    prev = led;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) bus.SW2 = 1'b0;
      cyc();
      if (led != prev && q.size() < 3) q.push_back(led);
      prev = led;
    end
    n_tests++;
    if (dut.r_dir !== DIR_DOWN) begin n_fail++; $display("FAIL dir_toggle got %0d want %0d", dut.r_dir, DIR_DOWN); end
`ifdef SATURATE_EN
    n_tests++;
    if (q.size() != 2 || q[0] !== 8'h01 || q[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL dir_sat_seq got %0d steps last led %h want 01,00", q.size(), led);
    end
    n_tests++;
    if (led !== 8'h00 || dut.r_state !== ST_STOPPED) begin
      n_fail++;
      $display("FAIL dir_sat_stop led %h state %0d want 00 / 0", led, dut.r_state);
    end
`else
    n_tests++;
    if (q.size() != 3) begin
      n_fail++;
      $display("FAIL dir_seq_len got %0d want 3", q.size());
    end else begin
      n_tests++;
      if (q[0] !== 8'h01 || q[1] !== 8'h00 || q[2] !== 8'hFF) begin
        n_fail++;
        $display("FAIL dir_wrap_seq got %h,%h,%h want 01,00,ff", q[0], q[1], q[2]);
      end
    end
`endif
  endtask

  task automatic test_stop_on_tick();
    bit ok;
    do_reset();
    bus.SW1 = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    bus.SW1 = 1'b0;
    wait_led(8'h01, 30, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL tick_reach1 led %h want 01", led); end
    cyc();
    bus.SW1 = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    n_tests++;
    if (led !== 8'h01 || dut.r_state !== ST_STOPPED) begin
      n_fail++;
      $display("FAIL stop_on_tick led %h state %0d want 01 / 0", led, dut.r_state);
    end
    for (int i = 0; i < 3; i++) cyc();
    bus.SW1 = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    n_tests++;
    if (led !== 8'h01 || dut.r_state !== ST_STOPPED) begin
      n_fail++;
      $display("FAIL stopped_hold led %h state %0d want 01 / 0", led, dut.r_state);
    end
    bus.SW1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      n_tests++;
      if (led !== ((k < 15) ? 8'h01 : 8'h02)) begin
        n_fail++;
        $display("FAIL restart_step edge %0d led %h want %h", k, led, (k < 15) ? 8'h01 : 8'h02);
      end
    end
    bus.SW1 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_reset();
    bus.SW1 = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    bus.SW1 = 1'b0;
    wait_led(8'h05, 60, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_reach5 led %h want 05", led); end
    bus.SW2 = 1'b1;
    cyc(); cyc(); cyc();
    bus.SW2 = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (led !== 8'h00 || dut.r_state !== ST_STOPPED || dut.r_dir !== DIR_UP) begin
      n_fail++;
      $display("FAIL rst_immediate led %h state %0d dir %0d want 00 / 0 / 0", led, dut.r_state, dut.r_dir);
    end
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    n_tests++;
    if (led !== 8'h00 || dut.r_state !== ST_STOPPED || dut.r_dir !== DIR_UP) begin
      n_fail++;
      $display("FAIL rst_no_pending led %h state %0d dir %0d want 00 / 0 / 0", led, dut.r_state, dut.r_dir);
    end
    bus.SW1 = 1'b1;
    for (int k = 1; k <= 15; k++) cyc();
    n_tests++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL rst_restart led %h want 01", led); end
    bus.SW1 = 1'b0;
  endtask

  task automatic test_random();
    int hold1;
    int hold2;
    hold1 = 0;
    hold2 = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (hold1 == 0) begin
        bus.SW1 = ($urandom_range(0, 3) == 0);
        hold1 = $urandom_range(1, 24);
      end
      if (hold2 == 0) begin
        bus.SW2 = ($urandom_range(0, 2) == 0);
        hold2 = $urandom_range(1, 24);
      end
      hold1--;
      hold2--;
      cyc();
      n_tests++;
      if (led !== m_count[7:0] || dut.r_state !== m_state() || dut.r_dir !== m_dir) begin
        n_fail++;
        $display("FAIL random cycle %0d led %h state %0d dir %0d want %h / %0d / %0d",
                 i, led, dut.r_state, dut.r_dir, m_count[7:0], m_state(), m_dir);
      end
    end
    bus.SW1 = 1'b0;
    bus.SW2 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.SW1 = 1'b0;
    bus.SW2 = 1'b0;
    model_reset();
    test_reset();
    test_press();
    test_glitch();
    test_direction();
    test_stop_on_tick();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
Button-driven controller for the 8-bit prescaled LED counter on the icezum board. It conditions the two pushbuttons and runs a small run/stop and direction FSM. It gates the prescaler and steps the 8-bit count up or down, driving LED7..LED0. This replaces the free-running counter top with a user-sequenced one.

Parameters:
N, 18, prescaler width; one count step every 2^N CLK cycles while running
DB_BITS, 16, debounce counter width; input must be stable 2^DB_BITS cycles to be accepted

Ports:
CLK  input  1  system clock (12 MHz on icezum)
RSTN  input  1  asynchronous, active-low reset
SW1  input  1  pushbuttons, active-high, asynchronous; start/stop toggle
SW2  input  1  pushbuttons, active-high, asynchronous; direction toggle
LED0..LED7  output  1 each  count[0]..count[7], registered

Behaviour:
- Reset (RSTN low, async) sets:
  - count=0, all LEDs 0
  - state=STOPPED, dir=UP
  - prescaler=0
  - synchronisers, debounced values and debounce counters all 0
- Input path, per button:
  - 2-FF synchroniser feeds the debouncer.
  - Debounce counter clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments. When it reaches all-ones and the input still differs, the debounced value takes the synced value and the counter clears.
  - Press pulse = 1-cycle rising edge of the debounced value. Releases produce no event.
  - Press latency from a clean input edge: 2 sync + 2^DB_BITS + 1 cycles.
- FSM states: STOPPED, RUN_UP, RUN_DOWN.
  - STOPPED + press1 -> RUN_UP if dir=UP, else RUN_DOWN. Prescaler cleared to 0.
  - RUN_x + press1 -> STOPPED. Prescaler holds its value and count holds.
  - press2 in any state toggles dir. In RUN_UP/RUN_DOWN the state swaps to the other run state in the same cycle.
  - press1 and press2 in the same cycle: both applied (dir toggles, run toggles). From STOPPED, the new run direction uses the toggled dir.
- Prescaler: N-bit counter, increments only in RUN states.
  - tick = RUN state and prescaler all-ones.
  - First tick arrives exactly 2^N cycles after leaving STOPPED; later ticks every 2^N cycles.
- Count update on tick:
  - RUN_UP: count+1 mod 256 (255 -> 0).
  - RUN_DOWN: count-1 mod 256 (0 -> 255).
  - LEDs reflect the new value the cycle after the tick.
- Simultaneous events:
  - tick + press1 (stop): stop wins, count not updated.
  - tick + press2: count steps in the old direction, then the direction changes.
- Reset mid-run: immediate return to the reset values above; no pending press survives.

Optional Feature:
SATURATE_EN
- Defined:
  - RUN_UP at 255 on tick: count stays 255 and state -> STOPPED.
  - RUN_DOWN at 0 on tick: count stays 0 and state -> STOPPED.
  - dir is unchanged.
- Undefined: wrap-around as described above.

Decomposition:
- Package contador_pkg:
  - state encoding constants ST_STOPPED=2'd0, ST_RUN_UP=2'd1, ST_RUN_DOWN=2'd2
  - DIR_UP=1'b0, DIR_DOWN=1'b1
  - default N and DB_BITS values
- Sub-module debouncer (synchroniser + debounce + rising-edge pulse, parameter DB_BITS), instantiated once per button.
- FSM, prescaler and count remain in contador_ctrl.

Test Plan:
Bench parameters: N=3, DB_BITS=2.
1. Reset, then idle 100 cycles -> LEDs=0x00, no ticks, state STOPPED.
2. Clean SW1 press -> press pulse 7 cycles after the edge. First step 8 cycles later, LEDs 0x01. Then 0x02, 0x03 every 8 cycles.
3. SW1 glitch of 3 cycles (shorter than 2 sync + 4) -> no press, LEDs stay 0x00. Hold 20 cycles -> exactly one press.
4. Running up at 0x02, press SW2 -> next steps 0x01, 0x00, 0xFF (wrap). With SATURATE_EN: stays 0x00 and state STOPPED.
5. Force press1 in the same cycle as a tick -> count unchanged, state STOPPED. Press SW1 again -> next step exactly 8 cycles later.
6. Assert RSTN low for 1 cycle mid-run at LEDs=0x05 -> LEDs 0x00 immediately, state STOPPED, dir UP. No steps until a new SW1 press.
